// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Instruction-fetch initiator for the multi-cycle processor. Walks the word PC
// through the instruction memory, latches each returned word into the IR and
// offers it to the decode/control FSM through a valid/ready handshake. Branch
// and jump logic can redirect the PC at any time; a redirect discards whatever
// fetch is in flight and any IR not yet consumed.
//
// A fetch takes three cycles: ISSUE (strobe memory), WAIT (memory output
// settles, IR captured on the closing edge), VALID (IR offered to consumer).
// An instruction whose opcode is HALT_OP parks the unit in HALT once it has
// been consumed; start resumes at the following address.
//
// Optional feature (macro INST_FETCH_BOOT_LOAD_EN): adds a boot-load write
// port so the instruction memory can be filled while the unit is IDLE or
// HALT. Without the macro the unit never writes memory.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin (IDLE) or resume (HALT) fetching
//   redirect          load redirect_pc into the PC, drop in-flight fetch
//   redirect_pc       redirect target word address
//   ir_ready          consumer accepts the current IR
//   ir_valid          IR holds an unconsumed instruction
//   ir, ir_pc         fetched instruction and the address it came from
//   pc                next fetch address
//   halted            unit is parked in HALT
//   im_addr           instruction memory address
//   im_datain         instruction memory write data
//   im_sigwr          instruction memory write enable
//   im_sigon          instruction memory access enable
//   im_dataout        instruction memory read data
//   ld_valid/ld_addr/ld_data/ld_ack  boot-load port (macro only)
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter int                ADDR_W   = 7,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [5:0]        HALT_OP  = 6'b111111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              ir_ready,
    output logic              ir_valid,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_datain,
    output logic              im_sigwr,
    output logic              im_sigon,
`ifdef INST_FETCH_BOOT_LOAD_EN
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ack,
`endif
    input  logic [DATA_W-1:0] im_dataout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        VALID = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t            state;
    logic              fetch_on;    // registered read strobe for ISSUE/WAIT
    logic [ADDR_W-1:0] fetch_addr;  // registered read address for ISSUE/WAIT
    logic              ld_fire;     // boot-load write happening this cycle

`ifdef INST_FETCH_BOOT_LOAD_EN
    // A load is only honoured while parked; it overrides the (idle) read
    // strobes combinationally for exactly the cycle ld_valid is high.
    assign ld_fire   = ld_valid && !rst && (state == IDLE || state == HALT);
    assign ld_ack    = ld_fire;
    assign im_sigon  = fetch_on | ld_fire;
    assign im_sigwr  = ld_fire;
    assign im_addr   = ld_fire ? ld_addr : fetch_addr;
    assign im_datain = ld_fire ? ld_data : '0;
`else
    assign ld_fire   = 1'b0;
    assign im_sigon  = fetch_on;
    assign im_sigwr  = 1'b0;
    assign im_addr   = fetch_addr;
    assign im_datain = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            ir         <= '0;
            ir_pc      <= '0;
            ir_valid   <= 1'b0;
            halted     <= 1'b0;
            fetch_on   <= 1'b0;
            fetch_addr <= '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    // Redirect only moves the PC while parked; a load in the
                    // same cycle swallows start.
                    if (redirect) begin
                        pc <= redirect_pc;
                    end else if (start && !ld_fire) begin
                        state      <= ISSUE;
                        halted     <= 1'b0;
                        fetch_on   <= 1'b1;
                        fetch_addr <= pc;
                    end
                end

                ISSUE: begin
                    if (redirect) begin
                        pc         <= redirect_pc;
                        fetch_addr <= redirect_pc;
                    end else begin
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (redirect) begin
                        // Abandon this read: no IR capture.
                        state      <= ISSUE;
                        pc         <= redirect_pc;
                        fetch_addr <= redirect_pc;
                    end else begin
                        state    <= VALID;
                        ir       <= im_dataout;
                        ir_pc    <= pc;
                        pc       <= pc + ADDR_W'(1);
                        ir_valid <= 1'b1;
                        fetch_on <= 1'b0;
                    end
                end

                VALID: begin
                    // Redirect beats a simultaneous ir_ready: the pending IR
                    // is treated as never consumed.
                    if (redirect) begin
                        state      <= ISSUE;
                        pc         <= redirect_pc;
                        ir_valid   <= 1'b0;
                        fetch_on   <= 1'b1;
                        fetch_addr <= redirect_pc;
                    end else if (ir_ready) begin
                        ir_valid <= 1'b0;
                        if (ir[DATA_W-1 -: 6] == HALT_OP) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            state      <= ISSUE;
                            fetch_on   <= 1'b1;
                            fetch_addr <= pc;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    ir_valid <= 1'b0;
                    halted   <= 1'b0;
                    fetch_on <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

    localparam int AW = 7;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          ir_ready;
    logic          ir_valid;
    logic [DW-1:0] ir;
    logic [AW-1:0] ir_pc;
    logic [AW-1:0] pc;
    logic          halted;
    logic [AW-1:0] im_addr;
    logic [DW-1:0] im_datain;
    logic          im_sigwr;
    logic          im_sigon;
    logic [DW-1:0] im_dataout;
`ifdef INST_FETCH_BOOT_LOAD_EN
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_ack;
`endif

    logic [DW-1:0] mem [128];
    assign im_dataout = mem[im_addr];

    always #5 clk = ~clk;

    inst_fetch_unit dut (
        .clk(clk), .rst(rst), .start(start), .redirect(redirect),
        .redirect_pc(redirect_pc), .ir_ready(ir_ready), .ir_valid(ir_valid),
        .ir(ir), .ir_pc(ir_pc), .pc(pc), .halted(halted), .im_addr(im_addr),
        .im_datain(im_datain), .im_sigwr(im_sigwr), .im_sigon(im_sigon),
`ifdef INST_FETCH_BOOT_LOAD_EN
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
`endif
        .im_dataout(im_dataout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic          s, r, d;
        logic [AW-1:0] rpc;
        logic          v, on;
        logic [AW-1:0] addr;
        logic [DW-1:0] ir;
        logic [AW-1:0] irpc, pc;
        logic          h;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic s, input logic r, input logic d, input logic [AW-1:0] rpc,
                       input logic v, input logic on, input logic [AW-1:0] addr,
                       input logic [DW-1:0] xir, input logic [AW-1:0] irpc,
                       input logic [AW-1:0] xpc, input logic h);
        vec_t t;
        t.s = s; t.r = r; t.d = d; t.rpc = rpc; t.v = v; t.on = on; t.addr = addr;
        t.ir = xir; t.irpc = irpc; t.pc = xpc; t.h = h;
        tbl.push_back(t);
    endtask

    localparam logic [DW-1:0] M0   = 32'h04200018;
    localparam logic [DW-1:0] M1   = 32'h4C010000;
    localparam logic [DW-1:0] M3   = 32'hFC000000;
    localparam logic [DW-1:0] M4   = 32'h44444444;
    localparam logic [DW-1:0] M50  = 32'h32323232;
    localparam logic [DW-1:0] M127 = 32'h7F7F7F7F;

    task automatic fill_mem();
        logic [DW-1:0] w;
        for (int i = 0; i < 128; i++) begin
            w = $urandom;
            if (w[31:26] == 6'h3F) w[31:26] = 6'h3E;
            mem[i] = w;
        end
    endtask

    task automatic idle_inputs();
        start = 0; redirect = 0; redirect_pc = '0; ir_ready = 0;
`ifdef INST_FETCH_BOOT_LOAD_EN
        ld_valid = 0; ld_addr = '0; ld_data = '0;
`endif
    endtask

    // Reference model state for the random phase
    logic [AW-1:0] m_addr;
    logic          m_valid;
    int            m_cnt;

    initial begin
        idle_inputs();
        rst = 1;
        fill_mem();
        mem[0] = M0; mem[1] = M1; mem[3] = M3; mem[4] = M4; mem[50] = M50; mem[127] = M127;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ir_valid", ir_valid, 0);
        chk("reset ir", ir, 0);
        chk("reset ir_pc", ir_pc, 0);
        chk("reset pc", pc, 0);
        chk("reset halted", halted, 0);
        chk("reset im_sigon", im_sigon, 0);
        chk("reset im_sigwr", im_sigwr, 0);
        chk("reset im_addr", im_addr, 0);
        chk("reset im_datain", im_datain, 0);
        rst = 0;

        //  s  r  d  rpc   v on addr ir    irpc pc  h
        add(1, 0, 0, 0,    0, 1, 0,   0,    0,   0,  0);
        add(0, 1, 0, 0,    0, 1, 0,   0,    0,   0,  0);
        add(0, 1, 0, 0,    1, 0, 0,   M0,   0,   1,  0);
        add(0, 1, 0, 0,    0, 1, 1,   M0,   0,   1,  0);
        add(0, 1, 0, 0,    0, 1, 1,   M0,   0,   1,  0);
        add(0, 1, 0, 0,    1, 0, 0,   M1,   1,   2,  0);
        add(0, 0, 0, 0,    1, 0, 0,   M1,   1,   2,  0);
        add(1, 0, 0, 0,    1, 0, 0,   M1,   1,   2,  0);
        add(0, 0, 0, 0,    1, 0, 0,   M1,   1,   2,  0);
        add(0, 0, 0, 0,    1, 0, 0,   M1,   1,   2,  0);
        add(0, 0, 0, 0,    1, 0, 0,   M1,   1,   2,  0);
        add(0, 1, 0, 0,    0, 1, 2,   M1,   1,   2,  0);
        add(0, 0, 0, 0,    0, 1, 2,   M1,   1,   2,  0);
        add(0, 0, 1, 50,   0, 1, 50,  M1,   1,   50, 0);
        add(0, 0, 0, 0,    0, 1, 50,  M1,   1,   50, 0);
        add(0, 0, 0, 0,    1, 0, 0,   M50,  50,  51, 0);
        add(0, 1, 1, 3,    0, 1, 3,   M50,  50,  3,  0);
        add(0, 0, 0, 0,    0, 1, 3,   M50,  50,  3,  0);
        add(0, 0, 0, 0,    1, 0, 0,   M3,   3,   4,  0);
        add(0, 1, 0, 0,    0, 0, 0,   M3,   3,   4,  1);
        add(0, 0, 0, 0,    0, 0, 0,   M3,   3,   4,  1);
        add(1, 0, 0, 0,    0, 1, 4,   M3,   3,   4,  0);
        add(0, 0, 0, 0,    0, 1, 4,   M3,   3,   4,  0);
        add(0, 0, 0, 0,    1, 0, 0,   M4,   4,   5,  0);
        add(0, 0, 1, 127,  0, 1, 127, M4,   4,   127,0);
        add(0, 0, 0, 0,    0, 1, 127, M4,   4,   127,0);
        add(0, 0, 0, 0,    1, 0, 0,   M127, 127, 0,  0);
        add(0, 1, 0, 0,    0, 1, 0,   M127, 127, 0,  0);
        add(0, 0, 0, 0,    0, 1, 0,   M127, 127, 0,  0);
        add(0, 0, 0, 0,    1, 0, 0,   M0,   0,   1,  0);
        add(0, 1, 0, 0,    0, 1, 1,   M0,   0,   1,  0);
        add(0, 0, 0, 0,    0, 1, 1,   M0,   0,   1,  0);

        foreach (tbl[i]) begin
            start = tbl[i].s; ir_ready = tbl[i].r; redirect = tbl[i].d; redirect_pc = tbl[i].rpc;
            @(negedge clk);
            chk($sformatf("row%0d ir_valid", i), ir_valid, tbl[i].v);
            chk($sformatf("row%0d im_sigon", i), im_sigon, tbl[i].on);
            if (tbl[i].on) chk($sformatf("row%0d im_addr", i), im_addr, tbl[i].addr);
            chk($sformatf("row%0d ir", i), ir, tbl[i].ir);
            chk($sformatf("row%0d ir_pc", i), ir_pc, tbl[i].irpc);
            chk($sformatf("row%0d pc", i), pc, tbl[i].pc);
            chk($sformatf("row%0d halted", i), halted, tbl[i].h);
            chk($sformatf("row%0d im_sigwr", i), im_sigwr, 0);
        end
        idle_inputs();

        // Reset during WAIT: the pending read must not reach the IR.
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst-mid ir", ir, 0);
        chk("rst-mid ir_pc", ir_pc, 0);
        chk("rst-mid ir_valid", ir_valid, 0);
        chk("rst-mid im_sigon", im_sigon, 0);
        chk("rst-mid pc", pc, 0);

`ifdef INST_FETCH_BOOT_LOAD_EN
        // Boot load in IDLE, with start in the same cycle (start swallowed).
        ld_valid = 1; ld_addr = 5; ld_data = 32'hDEADBEEF; start = 1;
        #1;
        chk("ld ack", ld_ack, 1);
        chk("ld sigwr", im_sigwr, 1);
        chk("ld sigon", im_sigon, 1);
        chk("ld addr", im_addr, 5);
        chk("ld datain", im_datain, 32'hDEADBEEF);
        if (im_sigwr) mem[im_addr] = im_datain;
        @(negedge clk);
        ld_valid = 0; start = 0;
        #1;
        chk("ld ack drop", ld_ack, 0);
        chk("ld sigwr drop", im_sigwr, 0);
        chk("ld start ignored", im_sigon, 0);
        redirect = 1; redirect_pc = 5;
        @(negedge clk);
        redirect = 0; start = 1;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        chk("ld readback valid", ir_valid, 1);
        chk("ld readback ir", ir, 32'hDEADBEEF);
        ld_valid = 1; ld_addr = 9; ld_data = 32'h12345678;
        #1;
        chk("ld in VALID ack", ld_ack, 0);
        chk("ld in VALID sigwr", im_sigwr, 0);
        @(negedge clk);
        ld_valid = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
`endif

        // Random phase against a countdown/queue-free reference model.
        fill_mem();
        redirect = 1; redirect_pc = 10;
        @(negedge clk);
        chk("idle redirect pc", pc, 10);
        chk("idle redirect no strobe", im_sigon, 0);
        redirect = 0; start = 1;
        @(negedge clk);
        start = 0;
        chk("start addr", im_addr, 10);
        m_addr = 10; m_valid = 0; m_cnt = 2;

        for (int it = 0; it < 400; it++) begin
            ir_ready    = ($urandom_range(1, 0) == 1);
            redirect    = ($urandom_range(9, 0) == 0);
            redirect_pc = AW'($urandom_range(127, 0));
            start       = ($urandom_range(7, 0) == 0);
            if (redirect) begin
                m_addr = redirect_pc; m_valid = 0; m_cnt = 2;
            end else if (m_valid) begin
                if (ir_ready) begin
                    m_addr = m_addr + 1'b1; m_valid = 0; m_cnt = 2;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) m_valid = 1;
            end
            @(negedge clk);
            chk($sformatf("rnd%0d ir_valid", it), ir_valid, m_valid);
            chk($sformatf("rnd%0d halted", it), halted, 0);
            chk($sformatf("rnd%0d im_sigwr", it), im_sigwr, 0);
            if (m_valid) begin
                chk($sformatf("rnd%0d ir", it), ir, mem[m_addr]);
                chk($sformatf("rnd%0d ir_pc", it), ir_pc, m_addr);
                chk($sformatf("rnd%0d pc", it), pc, AW'(m_addr + 1'b1));
                chk($sformatf("rnd%0d sigon", it), im_sigon, 0);
            end else begin
                chk($sformatf("rnd%0d pc", it), pc, m_addr);
                chk($sformatf("rnd%0d sigon", it), im_sigon, 1);
                chk($sformatf("rnd%0d im_addr", it), im_addr, m_addr);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
